// File: rtl/huff_freq_count4.sv
// huff_freq_count4
//
// Counts the occurrences of each 2-bit source symbol in a framed stream,
// using saturating 8-bit counters. At end of frame it packs the four counts
// into 13-bit leaf nodes {weight[7:0], id[4:0]}, presents them on registered
// outputs, and pulses sort_begin so the downstream 4-leaf sorter can start.
// After the pulse the nodes are held for HOLD_CYC cycles before a new frame
// is accepted.
//
// Ports:
//   CLK         clock, all state updates on the rising edge
//   nRST        asynchronous active-low reset
//   sym_valid   a symbol is present on sym
//   sym         source symbol index 0..3
//   sym_last    marks the last symbol of a frame (only meaningful on accept)
//   sym_ready   block can accept a symbol this cycle
//   node0..3    {weight of symbol i, 5'd i}, stable between frames
//   sort_begin  one-cycle start pulse to the sorter
//   busy        high while emitting and holding the nodes
module huff_freq_count4 #(
  parameter int HOLD_CYC = 6,
  parameter int CNT_MAX  = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        sym_valid,
  input  logic [1:0]  sym,
  input  logic        sym_last,
  output logic        sym_ready,
  output logic [12:0] node0,
  output logic [12:0] node1,
  output logic [12:0] node2,
  output logic [12:0] node3,
  output logic        sort_begin,
  output logic        busy
);

  localparam logic [7:0] CNT_MAX_W = 8'(CNT_MAX);
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EMIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt [4];
  logic [7:0]  hold_cnt;
  logic [12:0] node_r [4];
  logic        accept;

  // Saturating increment: a counter already at CNT_MAX stays there.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v >= CNT_MAX_W) return CNT_MAX_W;
    return v + 8'd1;
  endfunction

  assign accept = sym_valid && sym_ready;

  // Next-state and state-decoded outputs. sym_ready/busy depend only on the
  // state register, so there is no combinational path from sym_valid.
  always_comb begin
    state_nxt = state;
    sym_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE, COUNT: begin
        sym_ready = 1'b1;
        if (accept) state_nxt = sym_last ? EMIT : COUNT;
      end
      EMIT: begin
        busy      = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (hold_cnt == 8'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counting stage: the final symbol of a frame is counted on its accept
  // edge, so EMIT always sees the complete counts.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
    end else if (state == EMIT) begin
      for (int i = 0; i < 4; i++) cnt[i] <= 8'd0;
    end else if (accept) begin
      for (int i = 0; i < 4; i++) begin
        if (sym == 2'(i)) cnt[i] <= sat_inc(cnt[i]);
      end
    end
  end

  // Emit stage: nodes are captured only on the EMIT exit edge and then held
  // untouched until the next frame's EMIT.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 4; i++) node_r[i] <= 13'd0;
    end else if (state == EMIT) begin
      for (int i = 0; i < 4; i++) node_r[i] <= {cnt[i], 5'(i)};
    end
  end

  // Hold stage: sort_begin is high for exactly the first HOLD cycle; the
  // hold counter starts at HOLD_CYC-1 so HOLD lasts HOLD_CYC cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sort_begin <= 1'b0;
      hold_cnt   <= 8'd0;
    end else begin
      sort_begin <= (state == EMIT);
      if (state == EMIT) begin
        hold_cnt <= HOLD_INIT;
      end else if (state == HOLD && hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
    end
  end

  assign node0 = node_r[0];
  assign node1 = node_r[1];
  assign node2 = node_r[2];
  assign node3 = node_r[3];

endmodule
